// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// pic_pkg : OPTION/special-register constants shared by the PIC timer blocks
// Rev 1.0
// ============================================================================
package pic_pkg;

  // OPTION bit positions {T0CS, T0SE, PSA, PS2, PS1, PS0}
  localparam int c_opt_t0cs  = 5;
  localparam int c_opt_t0se  = 4;
  localparam int c_opt_psa   = 3;
  localparam int c_opt_ps_hi = 2;
  localparam int c_opt_ps_lo = 0;

  localparam logic [5:0] c_option_rst = 6'h3F;

  localparam logic [4:0] c_addr_tmr0   = 5'h01;
  localparam logic [4:0] c_addr_pcl    = 5'h02;
  localparam logic [4:0] c_addr_status = 5'h03;
  localparam logic [4:0] c_addr_fsr    = 5'h04;
  localparam logic [4:0] c_addr_porta  = 5'h05;
  localparam logic [4:0] c_addr_portb  = 5'h06;

  localparam logic [1:0] c_tmr0_inhibit = 2'd2;

  typedef struct packed {
    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
  } option_t;

  // Prescaler compare mask (2 << ps) - 1: 1:2 .. 1:256
  function automatic logic [7:0] ps_mask(input logic [2:0] ps);
    logic [8:0] m;
    m = (9'd2 << ps) - 9'd1;
    return m[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/t0cki_sync_edge.sv
`default_nettype none
// ============================================================================
// t0cki_sync_edge : T0CKI pin synchroniser with selectable-polarity edge strobe
// Rev 1.0
// ============================================================================
module t0cki_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic t0cki_i,
  input  logic t0se_i,
  output logic ext_evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   ext_evt_q;
  logic                   w_rise;
  logic                   w_fall;

  // hist_q extends the chain by one so the edge is taken between two settled stages
  assign w_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign w_fall = ~sync_q[SYNC_STAGES-1] & hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      ext_evt_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], t0cki_i};
      hist_q    <= sync_q[SYNC_STAGES-1];
      ext_evt_q <= t0se_i ? w_fall : w_rise;
    end
  end

  assign ext_evt_o = ext_evt_q;

endmodule
`default_nettype wire

// File: rtl/pic_tmr0_wdt_prescaler.sv
`default_nettype none
// ============================================================================
// pic_tmr0_wdt_prescaler : OPTION register, shared TMR0/WDT prescaler, WDT base
// Rev 1.0
// ============================================================================
module pic_tmr0_wdt_prescaler
  import pic_pkg::*;
#(
  parameter int WDT_PERIOD  = 18000,
  parameter int WDT_W       = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_tick_i,
  input  logic       t0cki_i,
  input  logic       option_wr_i,
  input  logic [5:0] option_in_i,
  input  logic       tmr0_wr_i,
  input  logic       clrwdt_i,
  input  logic       sleep_i,
  input  logic       wdt_en_i,
  output logic       tmr0_inc_o,
  output logic       wdtmr_o,
  output logic [5:0] option_q_o
);

  localparam logic [WDT_W-1:0] c_wdt_last = WDT_W'(WDT_PERIOD - 1);

  logic [5:0]       option_q,   option_d;
  logic [7:0]       prescaler_q, prescaler_d;
  logic [WDT_W-1:0] wdt_cnt_q,  wdt_cnt_d;
  logic [1:0]       inhibit_q,  inhibit_d;
  logic             tmr0_inc_q, tmr0_inc_d;
  logic             wdtmr_q,    wdtmr_d;

  option_t    w_opt;
  logic       w_ext_evt;
  logic       w_t0_evt;
  logic [7:0] w_mask;
  logic [7:0] w_wmask;
  logic       w_clr;
  logic       w_wdt_base;
  logic       w_inhibit;
  logic       w_psa_flip;

  t0cki_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_t0cki_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .t0cki_i   (t0cki_i),
    .t0se_i    (w_opt.t0se),
    .ext_evt_o (w_ext_evt)
  );

  // All decisions use the registered OPTION; a same-cycle write applies next cycle
  assign w_opt      = option_t'(option_q);
  assign w_t0_evt   = w_opt.t0cs ? w_ext_evt : instr_tick_i;
  assign w_mask     = ps_mask(w_opt.ps);
  assign w_wmask    = w_mask >> 1;
  assign w_clr      = clrwdt_i | sleep_i;
  assign w_wdt_base = wdt_en_i & ~w_clr & (wdt_cnt_q == c_wdt_last);
  assign w_inhibit  = (inhibit_q != 2'd0);
  assign w_psa_flip = option_wr_i & (option_in_i[c_opt_psa] != w_opt.psa);

  always_comb begin
    option_d = option_wr_i ? option_in_i : option_q;

    wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    if (!wdt_en_i || w_clr || (wdt_cnt_q == c_wdt_last)) begin
      wdt_cnt_d = '0;
    end

    inhibit_d = inhibit_q;
    if (tmr0_wr_i) begin
      inhibit_d = c_tmr0_inhibit;
    end else if (w_t0_evt && w_inhibit) begin
      inhibit_d = inhibit_q - 2'd1;
    end

    // Clears take priority over any count event in the same cycle
    prescaler_d = prescaler_q;
    if (w_psa_flip || (tmr0_wr_i && !w_opt.psa) || (w_clr && w_opt.psa)) begin
      prescaler_d = 8'd0;
    end else if (!w_opt.psa && w_t0_evt && !w_inhibit) begin
      prescaler_d = prescaler_q + 8'd1;
    end else if (w_opt.psa && w_wdt_base) begin
      prescaler_d = prescaler_q + 8'd1;
    end

    tmr0_inc_d = w_t0_evt && !tmr0_wr_i && !w_inhibit &&
                 (w_opt.psa || ((prescaler_q & w_mask) == w_mask));

    wdtmr_d = w_wdt_base &&
              (!w_opt.psa || ((prescaler_q & w_wmask) == w_wmask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      option_q    <= c_option_rst;
      prescaler_q <= 8'd0;
      wdt_cnt_q   <= '0;
      inhibit_q   <= 2'd0;
      tmr0_inc_q  <= 1'b0;
      wdtmr_q     <= 1'b0;
    end else begin
      option_q    <= option_d;
      prescaler_q <= prescaler_d;
      wdt_cnt_q   <= wdt_cnt_d;
      inhibit_q   <= inhibit_d;
      tmr0_inc_q  <= tmr0_inc_d;
      wdtmr_q     <= wdtmr_d;
    end
  end

  assign tmr0_inc_o = tmr0_inc_q;
  assign wdtmr_o    = wdtmr_q;
  assign option_q_o = option_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_tmr0_wdt_prescaler.sv
`default_nettype none
// ============================================================================
// tb_pic_tmr0_wdt_prescaler : scoreboard bench, expected pulse cycles queued
// Rev 1.0
// ============================================================================
module tb_pic_tmr0_wdt_prescaler;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_tick_i = 1'b0;
  logic       t0cki_i = 1'b0;
  logic       option_wr_i = 1'b0;
  logic [5:0] option_in_i = 6'h00;
  logic       tmr0_wr_i = 1'b0;
  logic       clrwdt_i = 1'b0;
  logic       sleep_i = 1'b0;
  logic       wdt_en_i = 1'b0;
  logic       tmr0_inc_o;
  logic       wdtmr_o;
  logic [5:0] option_q_o;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int n_tmr = 0;
  int tmr_q[$];
  int wdt_q[$];

  pic_tmr0_wdt_prescaler #(
    .WDT_PERIOD  (16),
    .WDT_W       (5),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_tick_i (instr_tick_i),
    .t0cki_i      (t0cki_i),
    .option_wr_i  (option_wr_i),
    .option_in_i  (option_in_i),
    .tmr0_wr_i    (tmr0_wr_i),
    .clrwdt_i     (clrwdt_i),
    .sleep_i      (sleep_i),
    .wdt_en_i     (wdt_en_i),
    .tmr0_inc_o   (tmr0_inc_o),
    .wdtmr_o      (wdtmr_o),
    .option_q_o   (option_q_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every observed pulse is matched against the oldest queued expectation
  always @(negedge clk) begin
    if (tmr0_inc_o) begin
      n_tmr++;
      if (tmr_q.size() == 0) chk("tmr0_inc_unexpected", cyc, -1);
      else                   chk("tmr0_inc_cycle", cyc, tmr_q.pop_front());
    end
    if (wdtmr_o) begin
      if (wdt_q.size() == 0) chk("wdtmr_unexpected", cyc, -1);
      else                   chk("wdtmr_cycle", cyc, wdt_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_cfg(input logic [5:0] opt, input logic wen, output int r);
    wdt_en_i = wen;
    rst = 1'b1;
    step(2);
    chk("rst_option", int'(option_q_o), 32'h3F);
    chk("rst_tmr0_inc", int'(tmr0_inc_o), 0);
    chk("rst_wdtmr", int'(wdtmr_o), 0);
    rst = 1'b0;
    option_wr_i = 1'b1;
    option_in_i = opt;
    r = cyc;
    step(1);
    option_wr_i = 1'b0;
    chk("option_load", int'(option_q_o), int'(opt));
  endtask

  task automatic end_phase(input string tag);
    chk({tag, "_tmr0_pending"}, tmr_q.size(), 0);
    chk({tag, "_wdt_pending"}, wdt_q.size(), 0);
    tmr_q.delete();
    wdt_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int start;

    // 1: instruction clock, 1:4
    reset_cfg(6'b000001, 1'b0, r);
    start = n_tmr;
    for (int n = 1; n <= 64; n++) begin
      step(3);
      instr_tick_i = 1'b1;
      if (n % 4 == 0) tmr_q.push_back(cyc + 1);
      step(1);
      instr_tick_i = 1'b0;
    end
    step(4);
    chk("t1_pulse_count", n_tmr - start, 16);
    end_phase("t1");

    // 2: T0CKI falling edges, 1:2
    reset_cfg(6'b110000, 1'b0, r);
    step(4);
    for (int m = 1; m <= 8; m++) begin
      t0cki_i = 1'b1;
      step(5);
      t0cki_i = 1'b0;
      if (m % 2 == 0) tmr_q.push_back(cyc + SYNC + 2);
      step(5);
    end
    step(8);
    end_phase("t2");

    // 3: WDT with prescaler at 1:1, then 1:8
    reset_cfg(6'b001000, 1'b1, r);
    for (int k = 1; k <= 4; k++) wdt_q.push_back(r + 16 * k);
    step(r + 66 - cyc);
    option_wr_i = 1'b1;
    option_in_i = 6'b001011;
    wdt_q.push_back(r + 128);
    wdt_q.push_back(r + 256);
    wdt_q.push_back(r + 384);
    step(1);
    option_wr_i = 1'b0;
    step(r + 400 - cyc);
    end_phase("t3");

    // 4: CLRWDT at terminal count, SLEEP mid-count
    reset_cfg(6'b000000, 1'b1, r);
    wdt_q.push_back(r + 16);
    wdt_q.push_back(r + 32);
    step(r + 47 - cyc);
    clrwdt_i = 1'b1;
    wdt_q.push_back(r + 64);
    step(1);
    clrwdt_i = 1'b0;
    step(r + 70 - cyc);
    sleep_i = 1'b1;
    wdt_q.push_back(r + 87);
    wdt_q.push_back(r + 103);
    step(1);
    sleep_i = 1'b0;
    step(r + 110 - cyc);
    end_phase("t4");

    // 5: TMR0 write inhibit, 1:2
    wdt_en_i = 1'b0;
    reset_cfg(6'b000000, 1'b0, r);
    step(2);
    instr_tick_i = 1'b1;
    step(1);
    instr_tick_i = 1'b0;
    chk("t5_prescaler_pre", int'(dut.prescaler_q), 1);
    step(3);
    instr_tick_i = 1'b1;
    tmr0_wr_i = 1'b1;
    step(1);
    instr_tick_i = 1'b0;
    tmr0_wr_i = 1'b0;
    chk("t5_prescaler_cleared", int'(dut.prescaler_q), 0);
    for (int i = 1; i <= 6; i++) begin
      step(3);
      instr_tick_i = 1'b1;
      if (i == 4 || i == 6) tmr_q.push_back(cyc + 1);
      step(1);
      instr_tick_i = 1'b0;
    end
    step(3);
    end_phase("t5");

    // 6: PSA switch clears prescaler, then reset overrides a pending increment
    reset_cfg(6'b000010, 1'b0, r);
    for (int i = 0; i < 5; i++) begin
      step(1);
      instr_tick_i = 1'b1;
      step(1);
      instr_tick_i = 1'b0;
    end
    chk("t6_prescaler_five", int'(dut.prescaler_q), 5);
    option_wr_i = 1'b1;
    option_in_i = 6'b001010;
    step(1);
    option_wr_i = 1'b0;
    chk("t6_prescaler_psa_flip", int'(dut.prescaler_q), 0);
    instr_tick_i = 1'b1;
    tmr_q.push_back(cyc + 1);
    step(1);
    instr_tick_i = 1'b0;
    step(1);
    instr_tick_i = 1'b1;
    rst = 1'b1;
    step(1);
    instr_tick_i = 1'b0;
    chk("t6_rst_tmr0_inc", int'(tmr0_inc_o), 0);
    chk("t6_rst_wdtmr", int'(wdtmr_o), 0);
    chk("t6_rst_option", int'(option_q_o), 32'h3F);
    rst = 1'b0;
    step(3);
    end_phase("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
